// File: rtl/ct_rtu_encode_arb.sv
// Registered request encoder for RTU slot selection: one-hot, LSB-first priority or
// round-robin search, presented through a single valid/ready output stage.
module ct_rtu_encode_arb #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned NUM_W = 5
) (
   input  logic             forever_cpuclk,
   input  logic             cpurst_b,
   input  logic [1:0]       x_mode,
   input  logic             x_in_vld,
   output logic             x_in_rdy,
   input  logic [WIDTH-1:0] x_num_expand,
   output logic             x_out_vld,
   input  logic             x_out_rdy,
   output logic [NUM_W-1:0] x_num,
   output logic [WIDTH-1:0] x_out_onehot,
   output logic             x_none,
   output logic             x_multi_err,
   output logic [NUM_W-1:0] x_rr_ptr
);

   if (int'(NUM_W) != $clog2(WIDTH) || WIDTH < 2 || WIDTH > 64) begin : g_param_chk
      $error("ct_rtu_encode_arb: NUM_W must equal $clog2(WIDTH), WIDTH in 2..64");
   end

   logic             out_vld_q;
   logic [NUM_W-1:0] num_q, num_d;
   logic [WIDTH-1:0] oh_q, oh_d;
   logic             none_q, none_d;
   logic             multi_q, multi_d;
   logic [NUM_W-1:0] rr_ptr_q, rr_ptr_d;

   logic             accept;
   logic [NUM_W-1:0] or_idx, lo_idx, hi_idx, rr_idx;
   logic [WIDTH-1:0] lo_oh, hi_oh, rr_oh;
   logic             seen, multi, hi_found;

   assign x_in_rdy = ~out_vld_q | x_out_rdy;
   assign accept   = x_in_vld & x_in_rdy;

   // Single ascending scan: OR of set indices, lowest set bit, and lowest set bit at or
   // above the round-robin pointer. If nothing sits at/above the pointer the search wraps,
   // which is simply the lowest set bit overall.
   always_comb begin
      or_idx   = '0;
      lo_idx   = '0;
      hi_idx   = '0;
      lo_oh    = '0;
      hi_oh    = '0;
      seen     = 1'b0;
      multi    = 1'b0;
      hi_found = 1'b0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         if (x_num_expand[i]) begin
            or_idx = or_idx | NUM_W'(i);
            if (seen) begin
               multi = 1'b1;
            end else begin
               lo_idx   = NUM_W'(i);
               lo_oh[i] = 1'b1;
            end
            if (!hi_found && (NUM_W'(i) >= rr_ptr_q)) begin
               hi_idx   = NUM_W'(i);
               hi_oh[i] = 1'b1;
               hi_found = 1'b1;
            end
            seen = 1'b1;
         end
      end
      rr_idx = hi_found ? hi_idx : lo_idx;
      rr_oh  = hi_found ? hi_oh  : lo_oh;
   end

   always_comb begin
      num_d   = '0;
      oh_d    = '0;
      multi_d = 1'b0;
      none_d  = ~seen;
      case (x_mode)
         2'b00: begin
            num_d   = or_idx;
            oh_d    = x_num_expand;
            multi_d = multi;
         end
         2'b10: begin
            num_d = rr_idx;
            oh_d  = rr_oh;
         end
         default: begin
            num_d = lo_idx;
            oh_d  = lo_oh;
         end
      endcase

      rr_ptr_d = rr_ptr_q;
      if (accept && (x_mode == 2'b10) && seen) begin
         rr_ptr_d = (rr_idx == NUM_W'(WIDTH - 1)) ? '0 : rr_idx + NUM_W'(1);
      end
   end

   always_ff @(posedge forever_cpuclk) begin
      if (!cpurst_b) begin
         out_vld_q <= 1'b0;
         num_q     <= '0;
         oh_q      <= '0;
         none_q    <= 1'b0;
         multi_q   <= 1'b0;
         rr_ptr_q  <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         if (accept) begin
            out_vld_q <= 1'b1;
            num_q     <= num_d;
            oh_q      <= oh_d;
            none_q    <= none_d;
            multi_q   <= multi_d;
         end else if (x_out_rdy) begin
            out_vld_q <= 1'b0;
         end
      end
   end

   assign x_out_vld    = out_vld_q;
   assign x_num        = num_q;
   assign x_out_onehot = oh_q;
   assign x_none       = none_q;
   assign x_multi_err  = multi_q;
   assign x_rr_ptr     = rr_ptr_q;

endmodule

// File: tb/tb_ct_rtu_encode_arb.sv
// Scoreboard bench for ct_rtu_encode_arb: a 32-wide and a 20-wide instance driven with
// directed vectors; expected results queued at accept and popped on output handshake.
module tb_ct_rtu_encode_arb;

   typedef struct packed {
      logic [31:0] oh;
      logic [4:0]  num;
      logic        none;
      logic        multi;
      logic [4:0]  ptr;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  mode;
   logic        in_vld, in_rdy, out_vld, out_rdy, none, multi;
   logic [31:0] vec, oh;
   logic [4:0]  num, ptr;

   logic [1:0]  mode20;
   logic        in_vld20, in_rdy20, out_vld20, out_rdy20, none20, multi20;
   logic [19:0] vec20, oh20;
   logic [4:0]  num20, ptr20;

   exp_t exp_q[$];
   exp_t exp20_q[$];
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   ct_rtu_encode_arb #(.WIDTH(32), .NUM_W(5)) u_dut (
      .forever_cpuclk(clk),
      .cpurst_b      (rst_n),
      .x_mode        (mode),
      .x_in_vld      (in_vld),
      .x_in_rdy      (in_rdy),
      .x_num_expand  (vec),
      .x_out_vld     (out_vld),
      .x_out_rdy     (out_rdy),
      .x_num         (num),
      .x_out_onehot  (oh),
      .x_none        (none),
      .x_multi_err   (multi),
      .x_rr_ptr      (ptr)
   );

   ct_rtu_encode_arb #(.WIDTH(20), .NUM_W(5)) u_dut20 (
      .forever_cpuclk(clk),
      .cpurst_b      (rst_n),
      .x_mode        (mode20),
      .x_in_vld      (in_vld20),
      .x_in_rdy      (in_rdy20),
      .x_num_expand  (vec20),
      .x_out_vld     (out_vld20),
      .x_out_rdy     (out_rdy20),
      .x_num         (num20),
      .x_out_onehot  (oh20),
      .x_none        (none20),
      .x_multi_err   (multi20),
      .x_rr_ptr      (ptr20)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
      end
   endtask

   function automatic exp_t mk(input logic [4:0] n, input logic [31:0] o, input logic nn,
                               input logic m, input logic [4:0] p);
      exp_t e;
      e.num = n; e.oh = o; e.none = nn; e.multi = m; e.ptr = p;
      return e;
   endfunction

   always @(negedge clk) begin : mon32
      exp_t e;
      if (rst_n && out_vld && out_rdy) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_out32", 64'(out_vld), 64'(0));
         end else begin
            e = exp_q.pop_front();
            chk("num32", 64'(num), 64'(e.num));
            chk("onehot32", 64'(oh), 64'(e.oh));
            chk("none32", 64'(none), 64'(e.none));
            chk("multi32", 64'(multi), 64'(e.multi));
            chk("ptr32", 64'(ptr), 64'(e.ptr));
         end
      end
   end

   always @(negedge clk) begin : mon20
      exp_t e;
      if (rst_n && out_vld20 && out_rdy20) begin
         if (exp20_q.size() == 0) begin
            chk("unexpected_out20", 64'(out_vld20), 64'(0));
         end else begin
            e = exp20_q.pop_front();
            chk("num20", 64'(num20), 64'(e.num));
            chk("onehot20", 64'(oh20), 64'(e.oh));
            chk("none20", 64'(none20), 64'(e.none));
            chk("multi20", 64'(multi20), 64'(e.multi));
            chk("ptr20", 64'(ptr20), 64'(e.ptr));
         end
      end
   end

   // Present a vector and hold it until accepted; returns #1 after the accepting edge
   // with in_vld still high so consecutive calls are back-to-back.
   task automatic send(input logic [1:0] m, input logic [31:0] v, input exp_t e);
      int n = 0;
      mode = m; vec = v; in_vld = 1'b1;
      @(negedge clk);
      while (!in_rdy && n < 20) begin
         n++;
         @(negedge clk);
      end
      if (!in_rdy) begin
         checks++; errors++;
         $display("FAIL accept_timeout32: in_rdy=%0d, want 1", in_rdy);
      end else begin
         exp_q.push_back(e);
      end
      @(posedge clk); #1;
   endtask

   task automatic send20(input logic [1:0] m, input logic [19:0] v, input exp_t e);
      int n = 0;
      mode20 = m; vec20 = v; in_vld20 = 1'b1;
      @(negedge clk);
      while (!in_rdy20 && n < 20) begin
         n++;
         @(negedge clk);
      end
      if (!in_rdy20) begin
         checks++; errors++;
         $display("FAIL accept_timeout20: in_rdy=%0d, want 1", in_rdy20);
      end else begin
         exp20_q.push_back(e);
      end
      @(posedge clk); #1;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, want finish");
      $fatal(1);
   end

   initial begin : stim
      rst_n = 1'b0; in_vld = 1'b1; vec = 32'hFFFF_FFFF; mode = 2'b00; out_rdy = 1'b1;
      in_vld20 = 1'b0; vec20 = '0; mode20 = 2'b00; out_rdy20 = 1'b1;

      // Reset held two cycles with a valid input present
      @(posedge clk); @(posedge clk);
      @(negedge clk);
      chk("rst_out_vld", 64'(out_vld), 64'(0));
      chk("rst_num", 64'(num), 64'(0));
      chk("rst_onehot", 64'(oh), 64'(0));
      chk("rst_none", 64'(none), 64'(0));
      chk("rst_multi", 64'(multi), 64'(0));
      chk("rst_ptr", 64'(ptr), 64'(0));
      chk("rst_in_rdy", 64'(in_rdy), 64'(1));
      @(posedge clk); #1;
      rst_n = 1'b1; in_vld = 1'b0;
      @(negedge clk);
      chk("post_rst_vld_a", 64'(out_vld), 64'(0));
      @(negedge clk);
      chk("post_rst_vld_b", 64'(out_vld), 64'(0));
      @(posedge clk); #1;

      // Mode 00 legacy one-hot encode
      send(2'b00, 32'h0000_0400, mk(5'd10, 32'h0000_0400, 1'b0, 1'b0, 5'd0));
      send(2'b00, 32'h0000_0006, mk(5'd3,  32'h0000_0006, 1'b0, 1'b1, 5'd0));
      // Mode 01 and alias 11
      send(2'b01, 32'h8000_1010, mk(5'd4,  32'h0000_0010, 1'b0, 1'b0, 5'd0));
      in_vld = 1'b0;
      @(negedge clk); @(negedge clk);
      chk("drain_vld", 64'(out_vld), 64'(0));
      chk("drain_num_hold", 64'(num), 64'(4));
      chk("drain_oh_hold", 64'(oh), 64'(32'h0000_0010));
      @(posedge clk); #1;
      send(2'b11, 32'h0000_0300, mk(5'd8,  32'h0000_0100, 1'b0, 1'b0, 5'd0));
      send(2'b01, 32'h0000_0000, mk(5'd0,  32'h0000_0000, 1'b1, 1'b0, 5'd0));

      // Mode 10 three back-to-back accepts, pointer wraps from 31
      send(2'b10, 32'h8000_0011, mk(5'd0,  32'h0000_0001, 1'b0, 1'b0, 5'd1));
      send(2'b10, 32'h8000_0011, mk(5'd4,  32'h0000_0010, 1'b0, 1'b0, 5'd5));
      send(2'b10, 32'h8000_0011, mk(5'd31, 32'h8000_0000, 1'b0, 1'b0, 5'd0));
      in_vld = 1'b0;
      @(posedge clk); @(posedge clk); #1;

      // Backpressure: result stalls, then same-cycle drain and accept
      out_rdy = 1'b0;
      send(2'b01, 32'h0000_0008, mk(5'd3, 32'h0000_0008, 1'b0, 1'b0, 5'd0));
      in_vld = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("stall_in_rdy", 64'(in_rdy), 64'(0));
         chk("stall_vld", 64'(out_vld), 64'(1));
         chk("stall_num", 64'(num), 64'(3));
         chk("stall_oh", 64'(oh), 64'(32'h0000_0008));
         chk("stall_ptr", 64'(ptr), 64'(0));
      end
      @(posedge clk); #1;
      out_rdy = 1'b1;
      send(2'b10, 32'h0000_0002, mk(5'd1, 32'h0000_0002, 1'b0, 1'b0, 5'd2));
      chk("same_cycle_vld", 64'(out_vld), 64'(1));

      // Zero vector in mode 10 with the pointer at 7
      send(2'b10, 32'h0000_0040, mk(5'd6, 32'h0000_0040, 1'b0, 1'b0, 5'd7));
      send(2'b10, 32'h0000_0000, mk(5'd0, 32'h0000_0000, 1'b1, 1'b0, 5'd7));
      in_vld = 1'b0;
      @(posedge clk); @(posedge clk); #1;

      // Reset while a result is stalled drops it and clears the pointer
      out_rdy = 1'b0;
      send(2'b10, 32'h0000_0100, mk(5'd8, 32'h0000_0100, 1'b0, 1'b0, 5'd9));
      in_vld = 1'b0;
      @(negedge clk);
      chk("pre_rst_ptr", 64'(ptr), 64'(9));
      chk("pre_rst_vld", 64'(out_vld), 64'(1));
      @(posedge clk); #1;
      rst_n = 1'b0;
      exp_q.delete();
      @(posedge clk);
      @(negedge clk);
      chk("midrst_vld", 64'(out_vld), 64'(0));
      chk("midrst_ptr", 64'(ptr), 64'(0));
      @(posedge clk); #1;
      rst_n = 1'b1; out_rdy = 1'b1;
      send(2'b10, 32'h0000_0001, mk(5'd0, 32'h0000_0001, 1'b0, 1'b0, 5'd1));
      in_vld = 1'b0;

      // WIDTH=20: bit 19 wins from ptr 4 and the pointer wraps to 0
      send20(2'b10, 20'h0_0008, mk(5'd3,  32'h0000_0008, 1'b0, 1'b0, 5'd4));
      send20(2'b10, 20'h8_0008, mk(5'd19, 32'h0008_0000, 1'b0, 1'b0, 5'd0));
      send20(2'b10, 20'h8_0008, mk(5'd3,  32'h0000_0008, 1'b0, 1'b0, 5'd4));
      send20(2'b01, 20'h8_0000, mk(5'd19, 32'h0008_0000, 1'b0, 1'b0, 5'd4));
      in_vld20 = 1'b0;

      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("sb_empty32", 64'(exp_q.size()), 64'(0));
      chk("sb_empty20", 64'(exp20_q.size()), 64'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
